data_memory_lsu: RTL and testbench

Parametrised data memory with a load/store front end. It is the next generation of the pipeline's data memory and sits in the MEM stage. It supports byte, halfword and word accesses with sign or zero extension, a configurable read latency, and a valid/ready request/response handshake. Alignment and range errors are flagged per access. After reset, an init FSM fills the array with a known pattern before the first request is accepted.

---
 rtl/data_memory_lsu.sv | 143 ++++++++++++++
 tb/tb_data_memory_lsu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// Word-organised data memory with a single-outstanding load/store front end.
// After reset an init sweep fills the array; requests are accepted only in IDLE.
module data_memory_lsu #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writeData,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       readData,
  output logic              resp_error,
  output logic              init_done,
  output logic [1:0]        dbgState
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH);
  localparam logic [1:0]        WAIT_INIT  = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  // Handshake: a request transfers on a posedge with req_valid && req_ready, a
  // response on a posedge with resp_valid && resp_ready; both sides hold until then.
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t            state, nextState;
  logic [IDX_W-1:0]  initCnt;
  logic [1:0]        waitCnt;
  logic [31:0]       rdReg;
  logic              errReg;
  logic              doneReg;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              reqErr;
  logic [IDX_W-1:0]  wordIdx;
  logic [31:0]       word;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       loadData;
  logic [3:0]        byteEn;
  logic [31:0]       wrLanes;

  assign accept  = req_valid && (state == IDLE);
  assign wordIdx = address[IDX_W+1:2];
  assign word    = mem[wordIdx];
  assign byteSel = word[8*address[1:0] +: 8];
  assign halfSel = address[1] ? word[31:16] : word[15:0];

  always_comb begin
    reqErr = 1'b0;
    if (req_size == 2'b11)                          reqErr = 1'b1;
    else if (address >= ADDR_LIMIT)                 reqErr = 1'b1;
    else if (req_size == 2'b01 && address[0])       reqErr = 1'b1;
    else if (req_size == 2'b10 && address[1:0] != 2'b00) reqErr = 1'b1;
  end

  always_comb begin
    loadData = word;
    byteEn   = 4'b1111;
    wrLanes  = writeData;
    case (req_size)
      2'b00: begin
        loadData = {{24{req_signed & byteSel[7]}}, byteSel};
        byteEn   = 4'b0001 << address[1:0];
        wrLanes  = {4{writeData[7:0]}};
      end
      2'b01: begin
        loadData = {{16{req_signed & halfSel[15]}}, halfSel};
        byteEn   = address[1] ? 4'b1100 : 4'b0011;
        wrLanes  = {2{writeData[15:0]}};
      end
      default: ;
    endcase
  end

  // No reset on the array: the INIT sweep is what defines its contents.
  always_ff @(posedge clock_in) begin
    if (state == INIT) begin
      mem[initCnt] <= (INIT_MODE != 0) ? 32'(initCnt) : 32'h0;
    end else if (accept && req_write && !reqErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrLanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      initCnt <= '0;
      waitCnt <= 2'd0;
      rdReg   <= 32'h0;
      errReg  <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state <= nextState;
      if (state == INIT) begin
        initCnt <= initCnt + 1'b1;
        if (initCnt == LAST_IDX) doneReg <= 1'b1;
      end
      if (accept) begin
        rdReg   <= (reqErr || req_write) ? 32'h0 : loadData;
        errReg  <= reqErr;
        waitCnt <= WAIT_INIT;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 2'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      INIT: if (initCnt == LAST_IDX) nextState = IDLE;
      IDLE: begin
        if (req_valid) begin
          if (reqErr || req_write || READ_LAT == 1) nextState = RESP;
          else                                      nextState = WAIT;
        end
      end
      WAIT: if (waitCnt == 2'd0) nextState = RESP;
      RESP: if (resp_ready) nextState = IDLE;
      default: nextState = INIT;
    endcase
  end

  // Response payload is gated by state so it reads 0 everywhere outside RESP.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign readData   = resp_valid ? rdReg : 32'h0;
  assign resp_error = resp_valid & errReg;
  assign init_done  = doneReg;
  assign dbgState   = state;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed cases plus random traffic against a
// byte-array reference model, with latency, stall-hold and reset checks.
module tb_data_memory_lsu;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int RL     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       write_data = 32'h0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       read_data;
  logic              resp_error;
  logic              init_done;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  mm [4*DEPTH];
  logic [32:0] exp_q [$];

  data_memory_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(RL), .INIT_MODE(1)) dut (
    .clock_in(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .address(address), .writeData(write_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .readData(read_data), .resp_error(resp_error),
    .init_done(init_done), .dbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory as a flat little-endian byte array.
  function automatic logic [32:0] model_access(input logic wr, input logic [1:0] sz,
      input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    if (sz == 2'd3 || a >= 4*DEPTH || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0))
      return {1'b1, 32'h0};
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++) mm[a + i] = wd[8*i +: 8];
      return 33'h0;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[a + i]) << (8*i));
    if (sg && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return {1'b0, v};
  endfunction

  task automatic model_init();
    for (int i = 0; i < 4*DEPTH; i++) mm[i] = (i % 4 == 0) ? 8'(i / 4) : 8'h00;
    exp_q.delete();
  endtask

  task automatic reset_and_init();
    int cyc;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    req_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!init_done && cyc < 100);
    check("init_cycles", 32'(cyc), 32'd16);
    check("init_req_ready", 32'(req_ready), 32'd1);
  endtask

  // driver: one request, full response handshake with optional stall
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
      input logic [31:0] a, input logic [31:0] wd, input int stall);
    logic [32:0] e;
    int w, lat, wexp;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; address = a; write_data = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model_access(wr, sz, sg, a, wd);
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
    wexp = (!wr && !e[32]) ? RL : 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check("resp_latency", 32'(lat), 32'(wexp));
    e = exp_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_data", read_data, e[31:0]);
      @(negedge clk);
    end
    check("read_data", read_data, e[31:0]);
    check("resp_error", 32'(resp_error), 32'(e[32]));
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("drop_valid", 32'(resp_valid), 32'd0);
    check("drop_data", read_data, 32'h0);
    check("drop_error", 32'(resp_error), 32'd0);
    check("drop_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic saw_resp;
    logic [31:0] a;
    reset_and_init();
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);

    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000007F, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'hB, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 0);

    do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hFFFFFFFF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h40, 32'h55, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h12345678, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5);

    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 4*DEPTH + 7));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, int'($urandom_range(0, 2)));
    end

    // reset while a load sits in WAIT
    do_req(1'b1, 2'd2, 1'b0, 32'hC, 32'hAABBCCDD, 0);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; address = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_valid", 32'(resp_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_data", read_data, 32'h0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    saw_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("midrst_no_resp", 32'(saw_resp), 32'd0);
    reset_and_init();
    do_req(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
